macc_req_sched: RTL

MACC_REQ_SCHED -- requirements
Module: macc_req_sched

---
 rtl/macc_sched_pkg.sv | 26 ++
 rtl/macc_rr_arb.sv | 37 +++
 rtl/macc_req_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/macc_sched_pkg.sv
// Shared types and constants for the MACC request scheduler.
// Holds the FSM encoding, core op codes, the default timeout and the round-robin pointer helper.
package macc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_e;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_SHL = 2'b11;

   localparam int unsigned TIMEOUT_DEF = 64;
   localparam int unsigned ID_W        = 3;

   // Requester index following idx, wrapping at nreq.
   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx,
                                                input int unsigned     nreq);
      return ((32'(idx) + 32'd1) >= nreq) ? '0 : (idx + ID_W'(1));
   endfunction

endpackage

// File: rtl/macc_rr_arb.sv
// Combinational round-robin arbiter.
// Grants the first valid requester at or after i_ptr, wrapping at NREQ.
module macc_rr_arb
   import macc_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] i_valid,
   input  logic [ID_W-1:0] i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [ID_W-1:0] o_idx,
   output logic            o_any
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   int unsigned w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_cand  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_cand = 32'(i_ptr) + i;
         if (w_cand >= NREQ) begin
            w_cand = w_cand - NREQ;
         end
         if (!o_any && i_valid[w_cand[IW-1:0]]) begin
            o_any                    = 1'b1;
            o_grant[w_cand[IW-1:0]]  = 1'b1;
            o_idx                    = ID_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/macc_req_sched.sv
// Round-robin scheduler sharing one ap_ctrl-style MACC core among NREQ requesters.
// Accepts one request in IDLE, starts the core, waits for done or timeout, then holds the response.
module macc_req_sched
   import macc_sched_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [DW*NREQ-1:0]   req_a,
   input  logic [DW*NREQ-1:0]   req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2:0]           rsp_id,
   output logic [DW-1:0]        rsp_data,
   output logic                 rsp_err,
   output logic                 core_start,
   input  logic                 core_ready,
   input  logic                 core_done,
   output logic [1:0]           core_op,
   output logic [DW-1:0]        core_a,
   output logic [DW-1:0]        core_b,
   input  logic [DW-1:0]        core_result,
   output logic                 busy
);

   localparam int unsigned TW = $clog2(TIMEOUT);

   sched_state_e r_state, w_state_nxt;

   logic [ID_W-1:0] r_rr_ptr,    w_rr_ptr_nxt;
   logic [TW-1:0]   r_tmo,       w_tmo_nxt;
   logic [ID_W-1:0] r_grant,     w_grant_nxt;
   logic [NREQ-1:0] r_req_ready, w_req_ready_nxt;
   logic            r_rsp_valid, w_rsp_valid_nxt;
   logic [DW-1:0]   r_rsp_data,  w_rsp_data_nxt;
   logic            r_rsp_err,   w_rsp_err_nxt;
   logic            r_core_start, w_core_start_nxt;
   logic [1:0]      r_core_op,   w_core_op_nxt;
   logic [DW-1:0]   r_core_a,    w_core_a_nxt;
   logic [DW-1:0]   r_core_b,    w_core_b_nxt;
   logic            r_busy,      w_busy_nxt;

   logic [NREQ-1:0] w_arb_grant;
   logic [ID_W-1:0] w_arb_idx;
   logic            w_arb_any;
   logic [1:0]      w_sel_op;
   logic [DW-1:0]   w_sel_a;
   logic [DW-1:0]   w_sel_b;

   macc_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .i_valid (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx),
      .o_any   (w_arb_any)
   );

   // Operand mux driven by the one-hot grant.
   always_comb begin
      w_sel_op = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_arb_grant[i]) begin
            w_sel_op = req_op[2*i +: 2];
            w_sel_a  = req_a[DW*i +: DW];
            w_sel_b  = req_b[DW*i +: DW];
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_rr_ptr_nxt     = r_rr_ptr;
      w_tmo_nxt        = '0;
      w_grant_nxt      = r_grant;
      w_req_ready_nxt  = '0;
      w_rsp_valid_nxt  = r_rsp_valid;
      w_rsp_data_nxt   = r_rsp_data;
      w_rsp_err_nxt    = r_rsp_err;
      w_core_start_nxt = r_core_start;
      w_core_op_nxt    = r_core_op;
      w_core_a_nxt     = r_core_a;
      w_core_b_nxt     = r_core_b;
      w_busy_nxt       = r_busy;

      unique case (r_state)
         ST_IDLE: begin
            if (w_arb_any) begin
               w_state_nxt      = ST_ISSUE;
               w_grant_nxt      = w_arb_idx;
               w_req_ready_nxt  = w_arb_grant;
               w_core_op_nxt    = w_sel_op;
               w_core_a_nxt     = w_sel_a;
               w_core_b_nxt     = w_sel_b;
               w_core_start_nxt = 1'b1;
               w_busy_nxt       = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (core_ready) begin
               w_core_start_nxt = 1'b0;
               if (core_done) begin
                  // Zero-latency core: result is already valid on the accept cycle.
                  w_state_nxt     = ST_RESP;
                  w_rsp_valid_nxt = 1'b1;
                  w_rsp_data_nxt  = core_result;
                  w_rsp_err_nxt   = 1'b0;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (core_done) begin
               w_state_nxt     = ST_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = core_result;
               w_rsp_err_nxt   = 1'b0;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_state_nxt     = ST_RESP;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_data_nxt  = '0;
               w_rsp_err_nxt   = 1'b1;
            end else begin
               w_tmo_nxt = r_tmo + TW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt     = ST_IDLE;
               w_rsp_valid_nxt = 1'b0;
               w_rr_ptr_nxt    = next_ptr(r_grant, NREQ);
               w_busy_nxt      = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rr_ptr     <= '0;
         r_tmo        <= '0;
         r_grant      <= '0;
         r_req_ready  <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_core_start <= 1'b0;
         r_core_op    <= '0;
         r_core_a     <= '0;
         r_core_b     <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_rr_ptr     <= w_rr_ptr_nxt;
         r_tmo        <= w_tmo_nxt;
         r_grant      <= w_grant_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_rsp_valid  <= w_rsp_valid_nxt;
         r_rsp_data   <= w_rsp_data_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
         r_core_start <= w_core_start_nxt;
         r_core_op    <= w_core_op_nxt;
         r_core_a     <= w_core_a_nxt;
         r_core_b     <= w_core_b_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = 3'(r_grant);
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign core_start = r_core_start;
   assign core_op    = r_core_op;
   assign core_a     = r_core_a;
   assign core_b     = r_core_b;
   assign busy       = r_busy;

endmodule
